// File: rtl/pipe_ex.sv
// Execute stage: single-cycle ALU plus a one-outstanding load/store sequencer
// against a data-memory request/response port. Results are held for writeback.
package liang_pkg;
  localparam int LIANG_XLEN = 32;

  typedef enum logic [1:0] {
    FU_ALU   = 2'd0,
    FU_LOAD  = 2'd1,
    FU_STORE = 2'd2
  } fu_op_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
    ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASS2
  } alu_op_t;

  typedef struct packed {
    logic [LIANG_XLEN-1:0] pc;
    logic [4:0]            rd;
    logic                  rd_wen;
    fu_op_t                fu_op;
    alu_op_t               alu_op;
    logic [1:0]            mem_size;
    logic                  mem_unsigned;
    logic                  ebreak;
  } uop_info_t;

  typedef struct packed {
    uop_info_t             uop_info;
    logic [LIANG_XLEN-1:0] opnd1;
    logic [LIANG_XLEN-1:0] opnd2;
    logic [LIANG_XLEN-1:0] imm;
    logic [LIANG_XLEN-1:0] store_data;
  } idToEx_t;

  typedef struct packed {
    uop_info_t             uop_info;
    logic [LIANG_XLEN-1:0] alu_res;
    logic [LIANG_XLEN-1:0] lsu_res;
  } exToWb_t;
endpackage

module pipe_ex
  import liang_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  idToEx_t         idToEx_i,
  input  logic            id_valid_i,
  output logic            ex_ready_o,
  output exToWb_t         exToWb_o,
  output logic            ex_valid_o,
  input  logic            wb_ready_i,
  output logic            dmem_req_valid_o,
  input  logic            dmem_req_ready_i,
  output logic            dmem_req_wen_o,
  output logic [XLEN-1:0] dmem_req_addr_o,
  output logic [XLEN-1:0] dmem_req_wdata_o,
  output logic [3:0]      dmem_req_wstrb_o,
  input  logic            dmem_rsp_valid_i,
  input  logic [XLEN-1:0] dmem_rsp_rdata_i,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_ex_valid;
  exToWb_t         r_ex_to_wb;
  logic [XLEN-1:0] r_store_data;

  logic            w_accept;
  logic [XLEN-1:0] w_alu_res;
  logic [4:0]      w_shamt;
  logic [1:0]      w_lane;
  logic            w_is_store;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load_res;

  // Every channel transfers on a cycle where valid && ready; the producer holds
  // its payload stable while valid && !ready.
  assign ex_ready_o = (r_state == S_IDLE) && (!r_ex_valid || wb_ready_i);
  assign w_accept   = id_valid_i && ex_ready_o;

  assign w_shamt = idToEx_i.opnd2[4:0];
  always_comb begin
    w_alu_res = '0;
    case (idToEx_i.uop_info.alu_op)
      ALU_ADD:   w_alu_res = idToEx_i.opnd1 + idToEx_i.opnd2;
      ALU_SUB:   w_alu_res = idToEx_i.opnd1 - idToEx_i.opnd2;
      ALU_AND:   w_alu_res = idToEx_i.opnd1 & idToEx_i.opnd2;
      ALU_OR:    w_alu_res = idToEx_i.opnd1 | idToEx_i.opnd2;
      ALU_XOR:   w_alu_res = idToEx_i.opnd1 ^ idToEx_i.opnd2;
      ALU_SLL:   w_alu_res = idToEx_i.opnd1 << w_shamt;
      ALU_SRL:   w_alu_res = idToEx_i.opnd1 >> w_shamt;
      ALU_SRA:   w_alu_res = $signed(idToEx_i.opnd1) >>> w_shamt;
      ALU_SLT:   w_alu_res = {{(XLEN-1){1'b0}}, $signed(idToEx_i.opnd1) < $signed(idToEx_i.opnd2)};
      ALU_SLTU:  w_alu_res = {{(XLEN-1){1'b0}}, idToEx_i.opnd1 < idToEx_i.opnd2};
      ALU_PASS2: w_alu_res = idToEx_i.opnd2;
      default:   w_alu_res = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && idToEx_i.uop_info.fu_op != FU_ALU) w_state_nxt = S_REQ;
      S_REQ:   if (dmem_req_ready_i) w_state_nxt = S_WAIT;
      S_WAIT:  if (dmem_rsp_valid_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The memory address lives in alu_res while the access is in flight.
  assign w_lane     = r_ex_to_wb.alu_res[1:0];
  assign w_is_store = (r_ex_to_wb.uop_info.fu_op == FU_STORE);
  assign w_byte     = dmem_rsp_rdata_i[{w_lane, 3'b000} +: 8];

  always_comb begin
    w_half = dmem_rsp_rdata_i[15:0];
    case (w_lane)
      2'd0: w_half = dmem_rsp_rdata_i[15:0];
      2'd1: w_half = dmem_rsp_rdata_i[23:8];
      2'd2: w_half = dmem_rsp_rdata_i[31:16];
      2'd3: w_half = {8'h00, dmem_rsp_rdata_i[31:24]};
      default: w_half = dmem_rsp_rdata_i[15:0];
    endcase
  end

  always_comb begin
    w_load_res = dmem_rsp_rdata_i;
    case (r_ex_to_wb.uop_info.mem_size)
      2'd0: w_load_res = {{(XLEN-8){w_byte[7] & ~r_ex_to_wb.uop_info.mem_unsigned}}, w_byte};
      2'd1: w_load_res = {{(XLEN-16){w_half[15] & ~r_ex_to_wb.uop_info.mem_unsigned}}, w_half};
      default: w_load_res = dmem_rsp_rdata_i;
    endcase
  end

  always_comb begin
    dmem_req_wstrb_o = 4'b0000;
    dmem_req_wdata_o = '0;
    if (r_state == S_REQ && w_is_store) begin
      case (r_ex_to_wb.uop_info.mem_size)
        2'd0: begin
          dmem_req_wstrb_o = 4'b0001 << w_lane;
          dmem_req_wdata_o = {(XLEN/8){r_store_data[7:0]}};
        end
        2'd1: begin
          dmem_req_wstrb_o = 4'b0011 << w_lane;
          dmem_req_wdata_o = {(XLEN/16){r_store_data[15:0]}};
        end
        default: begin
          dmem_req_wstrb_o = 4'b1111;
          dmem_req_wdata_o = r_store_data;
        end
      endcase
    end
  end

  assign dmem_req_valid_o = (r_state == S_REQ);
  assign dmem_req_wen_o   = (r_state == S_REQ) && w_is_store;
  assign dmem_req_addr_o  = r_ex_to_wb.alu_res;
  assign exToWb_o         = r_ex_to_wb;
  assign ex_valid_o       = r_ex_valid;
  assign dbg_state_o      = r_state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_ex_valid   <= 1'b0;
      r_ex_to_wb   <= '0;
      r_store_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_ex_to_wb.uop_info <= idToEx_i.uop_info;
        r_ex_to_wb.lsu_res  <= '0;
        if (idToEx_i.uop_info.fu_op == FU_ALU) begin
          r_ex_to_wb.alu_res <= w_alu_res;
          r_ex_valid         <= 1'b1;
        end else begin
          r_ex_to_wb.alu_res <= idToEx_i.opnd1 + idToEx_i.imm;
          r_store_data       <= idToEx_i.store_data;
          r_ex_valid         <= 1'b0;
        end
      end else if (r_state == S_WAIT && dmem_rsp_valid_i) begin
        r_ex_to_wb.lsu_res <= w_is_store ? '0 : w_load_res;
        r_ex_valid         <= 1'b1;
      end else if (r_ex_valid && wb_ready_i) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ex.sv
// Directed bench for pipe_ex: table-driven ALU and memory vectors plus
// hand-written sequences for reset, output hold and stray responses.
module tb_pipe_ex;
  import liang_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  idToEx_t       id_to_ex;
  logic          id_valid;
  logic          ex_ready;
  exToWb_t       ex_to_wb;
  logic          ex_valid;
  logic          wb_ready;
  logic          req_valid;
  logic          req_ready;
  logic          req_wen;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  pipe_ex #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .idToEx_i(id_to_ex), .id_valid_i(id_valid), .ex_ready_o(ex_ready),
    .exToWb_o(ex_to_wb), .ex_valid_o(ex_valid), .wb_ready_i(wb_ready),
    .dmem_req_valid_o(req_valid), .dmem_req_ready_i(req_ready),
    .dmem_req_wen_o(req_wen), .dmem_req_addr_o(req_addr),
    .dmem_req_wdata_o(req_wdata), .dmem_req_wstrb_o(req_wstrb),
    .dmem_rsp_valid_i(rsp_valid), .dmem_rsp_rdata_i(rsp_rdata),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic idToEx_t mk(input fu_op_t fu, input alu_op_t op, input logic [1:0] sz,
                                 input logic uns, input logic wen, input logic [4:0] rd,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic [31:0] sd);
    idToEx_t u;
    u = '0;
    u.uop_info.pc           = 32'h400 + {25'd0, rd, 2'b00};
    u.uop_info.rd           = rd;
    u.uop_info.rd_wen       = wen;
    u.uop_info.fu_op        = fu;
    u.uop_info.alu_op       = op;
    u.uop_info.mem_size     = sz;
    u.uop_info.mem_unsigned = uns;
    u.uop_info.ebreak       = rd[0];
    u.opnd1 = a;
    u.opnd2 = b;
    u.imm = imm;
    u.store_data = sd;
    return u;
  endfunction

  typedef struct {
    idToEx_t     u;
    logic [31:0] exp;
  } alu_vec_t;

  typedef struct {
    idToEx_t     u;
    int          ready_delay;
    int          rsp_delay;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic        exp_wen;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_lsu;
  } mem_vec_t;

  alu_vec_t alu_vecs[12];
  mem_vec_t mem_vecs[9];

  // driver: one memory uop from accept through writeback consume
  task automatic run_mem(input int idx, input mem_vec_t m);
    string tag;
    tag = $sformatf("mem%0d", idx);
    id_to_ex = m.u;
    id_valid = 1'b1;
    wb_ready = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(ex_ready), 32'd1);
    @(posedge clk); #1;
    id_valid = 1'b0;
    check({tag, "_valid_cleared"}, 32'(ex_valid), 32'd0);
    for (int k = 0; k <= m.ready_delay; k++) begin
      check({tag, "_req_valid"}, 32'(req_valid), 32'd1);
      check({tag, "_req_addr"}, req_addr, m.exp_addr);
      check({tag, "_req_wen"}, 32'(req_wen), 32'(m.exp_wen));
      check({tag, "_req_wstrb"}, 32'(req_wstrb), 32'(m.exp_wstrb));
      if (m.exp_wen) check({tag, "_req_wdata"}, req_wdata, m.exp_wdata);
      check({tag, "_busy_ready"}, 32'(ex_ready), 32'd0);
      check({tag, "_state_req"}, 32'(dbg_state), 32'd1);
      if (k == m.ready_delay) req_ready = 1'b1;
      @(posedge clk); #1;
      req_ready = 1'b0;
    end
    check({tag, "_req_dropped"}, 32'(req_valid), 32'd0);
    check({tag, "_state_wait"}, 32'(dbg_state), 32'd2);
    for (int k = 0; k < m.rsp_delay; k++) begin
      @(posedge clk); #1;
      check({tag, "_wait_valid"}, 32'(ex_valid), 32'd0);
    end
    rsp_valid = 1'b1;
    rsp_rdata = m.rdata;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    rsp_rdata = 32'h5A5A_A5A5;
    check({tag, "_done_valid"}, 32'(ex_valid), 32'd1);
    check({tag, "_lsu_res"}, ex_to_wb.lsu_res, m.exp_lsu);
    check({tag, "_alu_res_addr"}, ex_to_wb.alu_res, m.exp_addr);
    check({tag, "_rd_wen"}, 32'(ex_to_wb.uop_info.rd_wen), 32'(m.u.uop_info.rd_wen));
    check({tag, "_rd"}, 32'(ex_to_wb.uop_info.rd), 32'(m.u.uop_info.rd));
    check({tag, "_pc"}, ex_to_wb.uop_info.pc, m.u.uop_info.pc);
    check({tag, "_state_idle"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    idToEx_t ua, ub, uc;

    alu_vecs[0]  = '{mk(FU_ALU, ALU_ADD,   2'd0, 1'b0, 1'b1, 5'd1,  32'd5,        32'hFFFF_FFFE, 0, 0), 32'd3};
    alu_vecs[1]  = '{mk(FU_ALU, ALU_SRA,   2'd0, 1'b0, 1'b1, 5'd2,  32'h8000_0000, 32'd4,       0, 0), 32'hF800_0000};
    alu_vecs[2]  = '{mk(FU_ALU, ALU_SLTU,  2'd0, 1'b0, 1'b1, 5'd3,  32'd1,        32'hFFFF_FFFF, 0, 0), 32'd1};
    alu_vecs[3]  = '{mk(FU_ALU, ALU_SUB,   2'd0, 1'b0, 1'b1, 5'd4,  32'd3,        32'd5,         0, 0), 32'hFFFF_FFFE};
    alu_vecs[4]  = '{mk(FU_ALU, ALU_AND,   2'd0, 1'b0, 1'b1, 5'd5,  32'h0000_F0F0, 32'h0000_FF00, 0, 0), 32'h0000_F000};
    alu_vecs[5]  = '{mk(FU_ALU, ALU_OR,    2'd0, 1'b0, 1'b1, 5'd6,  32'h0000_F0F0, 32'h0000_FF00, 0, 0), 32'h0000_FFF0};
    alu_vecs[6]  = '{mk(FU_ALU, ALU_XOR,   2'd0, 1'b0, 1'b1, 5'd7,  32'h0000_F0F0, 32'h0000_FF00, 0, 0), 32'h0000_0FF0};
    alu_vecs[7]  = '{mk(FU_ALU, ALU_SLL,   2'd0, 1'b0, 1'b1, 5'd8,  32'd1,        32'h0000_003F, 0, 0), 32'h8000_0000};
    alu_vecs[8]  = '{mk(FU_ALU, ALU_SRL,   2'd0, 1'b0, 1'b1, 5'd9,  32'h8000_0000, 32'd4,       0, 0), 32'h0800_0000};
    alu_vecs[9]  = '{mk(FU_ALU, ALU_SLT,   2'd0, 1'b0, 1'b1, 5'd10, 32'hFFFF_FFFF, 32'd1,       0, 0), 32'd1};
    alu_vecs[10] = '{mk(FU_ALU, ALU_SLTU,  2'd0, 1'b0, 1'b1, 5'd11, 32'hFFFF_FFFF, 32'd1,       0, 0), 32'd0};
    alu_vecs[11] = '{mk(FU_ALU, ALU_PASS2, 2'd0, 1'b0, 1'b0, 5'd12, 32'hDEAD_0000, 32'h1234_5678, 0, 0), 32'h1234_5678};

    mem_vecs[0] = '{mk(FU_LOAD,  ALU_ADD, 2'd0, 1'b0, 1'b1, 5'd13, 32'h8000_0000, 0, 32'd3, 0),
                    0, 0, 32'h80FF_1234, 32'h8000_0003, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80};
    mem_vecs[1] = '{mk(FU_LOAD,  ALU_ADD, 2'd0, 1'b1, 1'b1, 5'd14, 32'h8000_0000, 0, 32'd3, 0),
                    0, 1, 32'h80FF_1234, 32'h8000_0003, 1'b0, 4'b0000, 32'h0, 32'h0000_0080};
    mem_vecs[2] = '{mk(FU_LOAD,  ALU_ADD, 2'd1, 1'b0, 1'b1, 5'd15, 32'h8000_0000, 0, 32'd2, 0),
                    1, 0, 32'h80FF_1234, 32'h8000_0002, 1'b0, 4'b0000, 32'h0, 32'hFFFF_80FF};
    mem_vecs[3] = '{mk(FU_LOAD,  ALU_ADD, 2'd1, 1'b1, 1'b1, 5'd16, 32'h0000_0010, 0, 32'd0, 0),
                    0, 0, 32'h0000_F00D, 32'h0000_0010, 1'b0, 4'b0000, 32'h0, 32'h0000_F00D};
    mem_vecs[4] = '{mk(FU_LOAD,  ALU_ADD, 2'd2, 1'b0, 1'b1, 5'd17, 32'h0000_0100, 0, 32'hFFFF_FFFC, 0),
                    0, 2, 32'hDEAD_BEEF, 32'h0000_00FC, 1'b0, 4'b0000, 32'h0, 32'hDEAD_BEEF};
    mem_vecs[5] = '{mk(FU_STORE, ALU_ADD, 2'd0, 1'b0, 1'b0, 5'd18, 32'h0000_1000, 0, 32'd1, 32'h1234_56AB),
                    3, 0, 32'hFFFF_FFFF, 32'h0000_1001, 1'b1, 4'b0010, 32'hABAB_ABAB, 32'h0};
    mem_vecs[6] = '{mk(FU_STORE, ALU_ADD, 2'd1, 1'b0, 1'b0, 5'd19, 32'h0000_2000, 0, 32'd2, 32'hCAFE_BEEF),
                    1, 0, 32'h1111_1111, 32'h0000_2002, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    mem_vecs[7] = '{mk(FU_STORE, ALU_ADD, 2'd2, 1'b0, 1'b1, 5'd20, 32'h0000_3000, 0, 32'd0, 32'h89AB_CDEF),
                    0, 0, 32'h2222_2222, 32'h0000_3000, 1'b1, 4'b1111, 32'h89AB_CDEF, 32'h0};
    mem_vecs[8] = '{mk(FU_STORE, ALU_ADD, 2'd1, 1'b0, 1'b0, 5'd21, 32'h0000_0003, 0, 32'd0, 32'h0000_7E57),
                    0, 0, 32'h0, 32'h0000_0003, 1'b1, 4'b1000, 32'h7E57_7E57, 32'h0};

    // reset held two cycles with a valid uop offered
    rst = 1'b1;
    id_valid = 1'b1;
    id_to_ex = alu_vecs[0].u;
    wb_ready = 1'b1;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("rst_ex_valid", 32'(ex_valid), 32'd0);
      check("rst_req_valid", 32'(req_valid), 32'd0);
      check("rst_wstrb", 32'(req_wstrb), 32'd0);
    end
    rst = 1'b0;
    id_valid = 1'b0;
    #1;
    check("post_rst_ready", 32'(ex_ready), 32'd1);
    @(posedge clk); #1;
    check("post_rst_no_accept", 32'(ex_valid), 32'd0);

    // back-to-back ALU vectors at one per cycle
    id_to_ex = alu_vecs[0].u;
    id_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check($sformatf("alu%0d_valid", i), 32'(ex_valid), 32'd1);
      check($sformatf("alu%0d_res", i), ex_to_wb.alu_res, alu_vecs[i].exp);
      check($sformatf("alu%0d_lsu", i), ex_to_wb.lsu_res, 32'd0);
      check($sformatf("alu%0d_pc", i), ex_to_wb.uop_info.pc, alu_vecs[i].u.uop_info.pc);
      check($sformatf("alu%0d_ebreak", i), 32'(ex_to_wb.uop_info.ebreak), 32'(alu_vecs[i].u.uop_info.ebreak));
      check($sformatf("alu%0d_rd_wen", i), 32'(ex_to_wb.uop_info.rd_wen), 32'(alu_vecs[i].u.uop_info.rd_wen));
      if (i < 11) id_to_ex = alu_vecs[i + 1].u;
      else id_valid = 1'b0;
    end
    @(posedge clk); #1;
    check("alu_consume_drop", 32'(ex_valid), 32'd0);

    // output hold while writeback stalls on the second of three uops
    ua = mk(FU_ALU, ALU_ADD, 2'd0, 1'b0, 1'b1, 5'd22, 32'd1,   32'd2,   0, 0);
    ub = mk(FU_ALU, ALU_ADD, 2'd0, 1'b0, 1'b1, 5'd23, 32'd10,  32'd20,  0, 0);
    uc = mk(FU_ALU, ALU_ADD, 2'd0, 1'b0, 1'b1, 5'd24, 32'd100, 32'd200, 0, 0);
    id_to_ex = ua;
    id_valid = 1'b1;
    @(posedge clk); #1;
    check("hold_a_res", ex_to_wb.alu_res, 32'd3);
    id_to_ex = ub;
    @(posedge clk); #1;
    check("hold_b_res", ex_to_wb.alu_res, 32'd30);
    wb_ready = 1'b0;
    id_to_ex = uc;
    #1;
    check("hold_ready_low", 32'(ex_ready), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(ex_valid), 32'd1);
      check("hold_res", ex_to_wb.alu_res, 32'd30);
      check("hold_rd", 32'(ex_to_wb.uop_info.rd), 32'd23);
      check("hold_ready", 32'(ex_ready), 32'd0);
    end
    wb_ready = 1'b1;
    #1;
    check("hold_release_ready", 32'(ex_ready), 32'd1);
    @(posedge clk); #1;
    id_valid = 1'b0;
    check("hold_c_valid", 32'(ex_valid), 32'd1);
    check("hold_c_res", ex_to_wb.alu_res, 32'd300);
    @(posedge clk); #1;
    check("hold_c_consumed", 32'(ex_valid), 32'd0);

    // stray response in IDLE
    rsp_valid = 1'b1;
    rsp_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    check("stray_rsp_valid", 32'(ex_valid), 32'd0);
    check("stray_rsp_state", 32'(dbg_state), 32'd0);

    // memory vectors
    for (int i = 0; i < 9; i++) run_mem(i, mem_vecs[i]);
    @(posedge clk); #1;
    check("mem_consume_drop", 32'(ex_valid), 32'd0);

    // reset while waiting for a load response, then a late response
    id_to_ex = mem_vecs[0].u;
    id_valid = 1'b1;
    @(posedge clk); #1;
    id_valid = 1'b0;
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    check("rstwait_state", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstwait_valid", 32'(ex_valid), 32'd0);
    check("rstwait_req", 32'(req_valid), 32'd0);
    check("rstwait_ready", 32'(ex_ready), 32'd1);
    rsp_valid = 1'b1;
    rsp_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    check("late_rsp_valid", 32'(ex_valid), 32'd0);
    check("late_rsp_state", 32'(dbg_state), 32'd0);
    id_to_ex = mk(FU_ALU, ALU_ADD, 2'd0, 1'b0, 1'b1, 5'd25, 32'd7, 32'd8, 0, 0);
    id_valid = 1'b1;
    @(posedge clk); #1;
    id_valid = 1'b0;
    check("after_rst_alu_valid", 32'(ex_valid), 32'd1);
    check("after_rst_alu_res", ex_to_wb.alu_res, 32'd15);
    check("after_rst_alu_rd", 32'(ex_to_wb.uop_info.rd), 32'd25);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
